vc_multi_counter_divider: RTL
=============================

Name: vc_multi_counter_divider

Overview:
- NUM_CH independent accumulating counters, each advanced by a runtime step when enabled, with per-channel clear and wrap or saturate overflow.
- A shared multi-cycle restoring divider returns quotient/remainder of any selected channel's counter through val/rdy request and response interfaces.
- Sits in the vc utility library as the multi-channel, runtime-configurable successor to the single fixed-addend, fixed-divisor counter.

Parameters:
DATA_WIDTH, 8, width of each counter, step, divisor, quotient and remainder
NUM_CH, 4, number of counter channels (>=2)
RESET_VALUE, 0, value every counter takes on reset or clear
SATURATE, 0, 0 = counters wrap modulo 2^DATA_WIDTH; 1 = clamp at all-ones

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel count enable
clr  in  NUM_CH  per-channel synchronous clear
step  in  DATA_WIDTH  addend applied to every enabled channel
counters  out  NUM_CH*DATA_WIDTH  flattened counter values, channel 0 in the LSBs
req_val  in  1  divide request valid
req_rdy  out  1  divider idle, can accept a request
req_ch  in  $clog2(NUM_CH)  channel to divide
req_divisor  in  DATA_WIDTH  divisor
resp_val  out  1  result valid
resp_rdy  in  1  consumer accepts result
resp_ch  out  $clog2(NUM_CH)  channel of result
resp_quotient  out  DATA_WIDTH  floor(counter/divisor)
resp_remainder  out  DATA_WIDTH  counter mod divisor
resp_dbz  out  1  divisor was zero

Behaviour:
- Reset: every counter = RESET_VALUE; FSM in IDLE; req_rdy=1; resp_val=0; resp_ch, resp_quotient, resp_remainder and resp_dbz all 0.
- Reset mid-operation aborts any division; no response is produced.
- Counter update, per channel, each edge:
  - clr has priority over en; clr loads RESET_VALUE.
  - Otherwise, en adds step with a 1-cycle visible latency.
  - Wrap mode: result is (c+step) mod 2^DATA_WIDTH.
  - Saturate mode: result is min(c+step, 2^DATA_WIDTH-1).
- Counters keep updating while a division runs; the division uses a snapshot.
- FSM states IDLE, CALC, DONE:
  - IDLE: req_rdy=1. On req_val, capture the counter[req_ch] value of that cycle (pre-update), the divisor and req_ch, then go to CALC.
  - CALC: one restoring quotient bit per cycle, MSB first, for exactly DATA_WIDTH cycles, then go to DONE. req_rdy=0.
  - DONE: resp_val=1 and all resp_* held stable until resp_rdy. On resp_val&&resp_rdy go to IDLE. req_rdy=0.
- Latency: accept in cycle 0; resp_val first high in cycle DATA_WIDTH+1. Independent of operand values.
- Back-to-back: the next request can be accepted no earlier than the cycle after the response handshake. No same-cycle pass-through.
- Divisor 0: same latency; quotient = all-ones, remainder = dividend, resp_dbz=1. resp_dbz=0 otherwise.
- All arithmetic is unsigned. The remainder register is DATA_WIDTH+1 bits internally to hold the trial-subtract borrow.
- req_ch >= NUM_CH: request is accepted and divides the value 0. Verification treats this as a don't-care.

Decomposition:
- Package vc_counter_div_pkg holds:
  - state_t enum {IDLE, CALC, DONE}
  - CH_W localparam helper
  - iteration-count width constant
- Sub-module vc_seq_divider: restoring divider with its own start/busy/done handshake, parametrised by DATA_WIDTH.
- The top level instantiates the counter array plus one vc_seq_divider and owns the val/rdy wrapping.

Test Plan:
1. Reset high 2 cycles, then low -> all counters = 0, req_rdy=1, resp_val=0. Issue a request during reset -> ignored.
2. DATA_WIDTH=8: en[1]=1, step=7 for 5 cycles -> counters ch1 = 35. Request ch1 with divisor 3 -> resp_val in cycle 9 with q=11, r=2, resp_ch=1, dbz=0.
3. Overflow: ch0 = 250, step=10. SATURATE=0 -> 4; SATURATE=1 -> 255. Same cycle clr[0]=1 and en[0]=1 -> RESET_VALUE.
4. Dividend 35, divisor 0 -> q=255, r=35, resp_dbz=1 after the same 9-cycle latency. Dividend 0, divisor 5 -> q=0, r=0.
5. Backpressure: hold resp_rdy=0 for 5 cycles with req_val=1 -> resp outputs stable, req_rdy=0. Raise resp_rdy -> next request accepted the following cycle. Ch2 counting during CALC does not change the result.
6. Reset asserted in cycle 4 of CALC -> next cycle IDLE, resp_val=0, counters = RESET_VALUE. A fresh request completes normally.

Source files
------------

// File: rtl/vc_counter_div_pkg.sv
// Shared types and width helpers for the multi-channel counter/divider slice.
package vc_counter_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of the divider's iteration counter (counts 0 .. w-1).
   function automatic int iter_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/vc_seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, MSB first.
// done is high during the cycle whose edge retires the final bit.
module vc_seq_divider
   import vc_counter_div_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  dbz
);

   localparam int IW = iter_w(DATA_WIDTH);
   localparam logic [IW-1:0] LAST_ITER = IW'(DATA_WIDTH - 1);

   logic                  busy_q, busy_d;
   logic [IW-1:0]         iter_q, iter_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH:0]   rem_q, rem_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic                  dbz_q, dbz_d;

   logic [DATA_WIDTH+1:0] rem_shift;
   logic [DATA_WIDTH:0]   trial;
   logic                  fits;

   // The quotient register doubles as the dividend shift source.
   always_comb begin
      busy_d    = busy_q;
      iter_d    = iter_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      dbz_d     = dbz_q;
      rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
      fits      = rem_shift >= {2'b00, dvs_q};
      trial     = rem_shift[DATA_WIDTH:0] - {1'b0, dvs_q};
      if (start && !busy_q) begin
         busy_d = 1'b1;
         iter_d = '0;
         quo_d  = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
         dbz_d  = (divisor == '0);
      end else if (busy_q) begin
         rem_d  = fits ? trial : rem_shift[DATA_WIDTH:0];
         quo_d  = {quo_q[DATA_WIDTH-2:0], fits};
         iter_d = iter_q + IW'(1);
         if (iter_q == LAST_ITER) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         iter_q <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         iter_q <= iter_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         dbz_q  <= dbz_d;
      end
   end

   assign busy      = busy_q;
   assign done      = busy_q && (iter_q == LAST_ITER);
   assign quotient  = quo_q;
   assign remainder = rem_q[DATA_WIDTH-1:0];
   assign dbz       = dbz_q;

endmodule

// File: rtl/vc_multi_counter_divider.sv
// NUM_CH stepping counters (wrap or saturate) plus one shared sequential
// divider that reports any channel's snapshot quotient/remainder via val/rdy.
module vc_multi_counter_divider
   import vc_counter_div_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned RESET_VALUE = 0,
   parameter bit          SATURATE    = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            en,
   input  logic [NUM_CH-1:0]            clr,
   input  logic [DATA_WIDTH-1:0]        step,
   output logic [NUM_CH*DATA_WIDTH-1:0] counters,
   input  logic                         req_val,
   output logic                         req_rdy,
   input  logic [ch_w(NUM_CH)-1:0]      req_ch,
   input  logic [DATA_WIDTH-1:0]        req_divisor,
   output logic                         resp_val,
   input  logic                         resp_rdy,
   output logic [ch_w(NUM_CH)-1:0]      resp_ch,
   output logic [DATA_WIDTH-1:0]        resp_quotient,
   output logic [DATA_WIDTH-1:0]        resp_remainder,
   output logic                         resp_dbz
);

   localparam int CH_W = ch_w(NUM_CH);
   localparam logic [DATA_WIDTH-1:0] RST_V = DATA_WIDTH'(RESET_VALUE);

   logic [DATA_WIDTH-1:0] cnt_q [NUM_CH];
   logic [DATA_WIDTH-1:0] cnt_d [NUM_CH];
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] snap;

   state_t            state_q;
   logic              req_rdy_q;
   logic              resp_val_q;
   logic [CH_W-1:0]   resp_ch_q;

   logic                  div_start, div_busy, div_done, div_dbz;
   logic [DATA_WIDTH-1:0] div_quo, div_rem;

   always_comb begin
      cnt_d = cnt_q;
      sum   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         sum = {1'b0, cnt_q[i]} + {1'b0, step};
         if (clr[i])
            cnt_d[i] = RST_V;
         else if (en[i])
            cnt_d[i] = (SATURATE && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= RST_V;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Out-of-range selects match no channel and so divide zero.
   always_comb begin
      snap     = '0;
      counters = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         counters[i*DATA_WIDTH +: DATA_WIDTH] = cnt_q[i];
         if (req_ch == CH_W'(i)) snap = cnt_q[i];
      end
   end

   assign div_start = (state_q == IDLE) && req_val && !div_busy;

   vc_seq_divider #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .dividend  (snap),
      .divisor   (req_divisor),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem),
      .dbz       (div_dbz)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         req_rdy_q  <= 1'b1;
         resp_val_q <= 1'b0;
         resp_ch_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (div_start) begin
               state_q   <= CALC;
               req_rdy_q <= 1'b0;
               resp_ch_q <= req_ch;
            end
            CALC: if (div_done) begin
               state_q    <= DONE;
               resp_val_q <= 1'b1;
            end
            DONE: if (resp_rdy) begin
               state_q    <= IDLE;
               resp_val_q <= 1'b0;
               req_rdy_q  <= 1'b1;
            end
            default: begin
               state_q    <= IDLE;
               req_rdy_q  <= 1'b1;
               resp_val_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_rdy        = req_rdy_q;
   assign resp_val       = resp_val_q;
   assign resp_ch        = resp_ch_q;
   assign resp_quotient  = div_quo;
   assign resp_remainder = div_rem;
   assign resp_dbz       = div_dbz;

endmodule
